result_writeback: RTL and testbench

Write-back engine for the convolution datapath. It accepts NUM_UNITS-lane result beats from the processing units over a valid/ready handshake and buffers them in a small FIFO. It generates raster addresses across the output feature map and drives the simple memory's write port (simple_write, simple_write_addr, simple_write_data). It yields the shared address port whenever a simple-memory read is in progress.

---
 rtl/ttpu_pkg.sv | 16 +
 rtl/result_writeback_fifo.sv | 51 +++++
 rtl/result_writeback.sv | 178 +++++++++++++++++
 tb/tb_result_writeback.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ttpu_pkg.sv
// Shared types and sizing helpers for the convolution datapath blocks.
package ttpu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wb_state_t;

    // Bits needed to index count items; never less than one.
    function automatic int idx_bits(input int count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

    // Flattened width of a lanes x lane_width result beat.
    function automatic int beat_bits(input int lanes, input int lane_width);
        return lanes * lane_width;
    endfunction

endpackage

// File: rtl/result_writeback_fifo.sv
// Small synchronous FIFO for result beats; the read data is visible before the pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit tells full from empty when the index bits match.
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/result_writeback.sv
// Buffers result beats and writes them in raster order to the simple memory port.
// Define RESULT_WRITEBACK_RELU_EN to clamp negative lanes to zero on write.
module result_writeback
    import ttpu_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int NUM_UNITS    = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = idx_bits(IMAGE_WIDTH * IMAGE_HEIGHT),
    parameter int KD_W         = idx_bits(IMAGE_WIDTH)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [ADDR_W-1:0]                      base_addr,
    input  logic [KD_W-1:0]                        kernel_dim,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]   in_data,
    input  logic                                   rd_busy,
    output logic                                   wr_en,
    output logic [NUM_UNITS-1:0][ADDR_W-1:0]       wr_addr,
    output logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]   wr_data,
    output logic                                   busy,
    output logic                                   done
);
    localparam int CNT_W  = idx_bits(IMAGE_WIDTH * IMAGE_HEIGHT + 1);
    localparam int LANE_W = idx_bits(NUM_UNITS);
    localparam int N_W    = CNT_W + LANE_W + 1;
    localparam int BEAT_W = beat_bits(NUM_UNITS, DATA_WIDTH);
    localparam int FIFO_W = BEAT_W + CNT_W;

    wb_state_t   state;
    logic [ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]  total_r;
    logic [CNT_W-1:0]  beats_r;
    logic [CNT_W-1:0]  accepted;

    int kd_eff;
    int total_int;
    int beats_int;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_dout;
    logic [CNT_W-1:0]  pop_idx;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] pop_beat;

    logic [N_W-1:0]                       last_n;
    logic [LANE_W-1:0]                    dup_lane;
    logic [NUM_UNITS-1:0][N_W-1:0]        lane_n;
    logic [NUM_UNITS-1:0][ADDR_W-1:0]     lane_addr;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] lane_data;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] out_data;

    // Job geometry from the kernel size; an oversized kernel yields an empty job.
    always_comb begin
        kd_eff    = (kernel_dim == '0) ? 1 : int'(kernel_dim);
        total_int = 0;
        if (kd_eff <= IMAGE_HEIGHT && kd_eff <= IMAGE_WIDTH) begin
            total_int = (IMAGE_WIDTH - kd_eff + 1) * (IMAGE_HEIGHT - kd_eff + 1);
        end
        beats_int = (total_int + NUM_UNITS - 1) / NUM_UNITS;
    end

    assign in_ready = (state == RUN) && !fifo_full && (accepted < beats_r);
    assign push     = in_valid && in_ready;
    assign pop      = !fifo_empty && !rd_busy;

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({accepted, in_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pop_idx  = fifo_dout[FIFO_W-1 -: CNT_W];
    assign pop_beat = fifo_dout[BEAT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            base_r   <= '0;
            total_r  <= '0;
            beats_r  <= '0;
            accepted <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_r   <= base_addr;
                        total_r  <= CNT_W'(total_int);
                        beats_r  <= CNT_W'(beats_int);
                        accepted <= '0;
                        busy     <= 1'b1;
                        done     <= (total_int == 0);
                        state    <= (total_int == 0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (push) begin
                        accepted <= accepted + CNT_W'(1);
                        if (accepted == beats_r - CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                // An empty FIFO here means the final pop already happened on an earlier edge.
                DRAIN: begin
                    if (fifo_empty) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lanes past the end of the map rewrite the last real result instead of spilling.
    always_comb begin
        last_n   = N_W'(total_r) - N_W'(1);
        dup_lane = LANE_W'(last_n % N_W'(NUM_UNITS));
        for (int i = 0; i < NUM_UNITS; i++) begin
            lane_n[i] = N_W'(pop_idx) * N_W'(NUM_UNITS) + N_W'(i);
            if (lane_n[i] < N_W'(total_r)) begin
                lane_addr[i] = base_r + lane_n[i][ADDR_W-1:0];
                lane_data[i] = pop_beat[i];
            end else begin
                lane_addr[i] = base_r + last_n[ADDR_W-1:0];
                lane_data[i] = pop_beat[dup_lane];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
`ifdef RESULT_WRITEBACK_RELU_EN
            out_data[i] = lane_data[i][DATA_WIDTH-1] ? '0 : lane_data[i];
`else
            out_data[i] = lane_data[i];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= pop;
            if (pop) begin
                wr_addr <= lane_addr;
                wr_data <= out_data;
            end
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: driver queues expected beats, a monitor checks every write.
module tb_result_writeback;
    localparam int DW = 16;
    localparam int AW = 6;
    localparam int KW = 3;
    localparam int NU = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic rd_busy = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [KW-1:0] kernel_dim = '0;
    logic [NU-1:0][DW-1:0] in_data = '0;
    logic in_ready;
    logic wr_en;
    logic busy;
    logic done;
    logic [NU-1:0][AW-1:0] wr_addr;
    logic [NU-1:0][DW-1:0] wr_data;

    logic [43:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cycle_cnt = 0;
    int last_wr_cycle = -100;

    always #5 clk = ~clk;

    result_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .kernel_dim (kernel_dim),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        n_cmp++;
        if (actual !== required) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef RESULT_WRITEBACK_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [43:0] expectBeat(input int k, input logic [AW-1:0] base,
                                               input int total, input logic [NU-1:0][DW-1:0] raw);
        logic [NU-1:0][AW-1:0] a;
        logic [NU-1:0][DW-1:0] d;
        int n;
        int src;
        src = (total - 1) % NU;
        for (int i = 0; i < NU; i++) begin
            n = k * NU + i;
            if (n < total) begin
                a[i] = base + AW'(n);
                d[i] = relu(raw[i]);
            end else begin
                a[i] = base + AW'(total - 1);
                d[i] = relu(raw[src]);
            end
        end
        return {a, d};
    endfunction

    // Monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        cycle_cnt++;
        if (wr_en === 1'b1) begin
            last_wr_cycle = cycle_cnt;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: actual wr_en=1 addr=%0h required no write", wr_addr);
            end else begin
                checkOutput("wr_beat", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic applyStimulus(input logic [AW-1:0] base, input logic [KW-1:0] kd, input int total,
                                 input int tag, input int busy_start, input int busy_len,
                                 input int stray_start_at, input bit neg_first,
                                 input bit expect_writes, input bit wait_done);
        int beats;
        int k;
        int c;
        int win_acc;
        bit prev_busy;
        logic [NU-1:0][DW-1:0] raw;
        beats = (total + NU - 1) / NU;
        @(negedge clk);
        base_addr  = base;
        kernel_dim = kd;
        start      = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        k         = 0;
        c         = 0;
        win_acc   = 0;
        prev_busy = 1'b0;
        while (k < beats && c < 1000) begin
            if (prev_busy) checkOutput("no_write_while_rd_busy", 64'(wr_en), 64'd0);
            if (busy_len == 6 && c == busy_start + 5)
                checkOutput("in_ready_low_when_full", 64'(in_ready), 64'd0);
            rd_busy   = (c >= busy_start) && (c < busy_start + busy_len);
            prev_busy = rd_busy;
            start     = (c == stray_start_at);
            if (start) begin
                base_addr  = base + AW'(10);
                kernel_dim = KW'(1);
            end
            for (int i = 0; i < NU; i++) raw[i] = DW'(tag * 256 + k * NU + i);
            if (neg_first && k == 0) raw[0] = 16'hFFF0;
            in_valid = 1'b1;
            in_data  = raw;
            if (in_ready === 1'b1) begin
                if (expect_writes) exp_q.push_back(expectBeat(k, base, total, raw));
                if (rd_busy) win_acc++;
                k++;
            end
            @(negedge clk);
            c++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = '0;
        checkOutput("beats_accepted", 64'(k), 64'(beats));
        if (busy_len == 6) checkOutput("accepts_during_rd_busy", 64'(win_acc), 64'd3);
        if (wait_done) begin
            rd_busy = 1'b0;
            c = 0;
            do begin
                @(negedge clk);
                #1;
                c++;
            end while (done !== 1'b1 && c < 100);
            checkOutput("done_seen", 64'(done), 64'd1);
            checkOutput("done_after_last_write", 64'(cycle_cnt - last_wr_cycle), 64'd1);
            checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
            @(negedge clk);
            #1;
            checkOutput("done_one_cycle", 64'(done), 64'd0);
            checkOutput("busy_cleared", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int done_cnt;
        #2 reset = 1'b1;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_wr_en", 64'(wr_en), 64'd0);
        checkOutput("reset_wr_addr", 64'(wr_addr), 64'd0);
        checkOutput("reset_wr_data", 64'(wr_data), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        #20 reset = 1'b0;

        // kd=3: 36 results in 18 beats, with a stray start mid-job that must be ignored
        applyStimulus(6'd0, 3'd3, 36, 1, -1, 0, 8, 1'b0, 1'b1, 1'b1);

        // kd=4: 25 results, final beat lane1 repeats address 24 and lane0 data
        applyStimulus(6'd0, 3'd4, 25, 2, -1, 0, -1, 1'b0, 1'b1, 1'b1);
        checkOutput("kd4_last_addr0", 64'(wr_addr[0]), 64'd24);
        checkOutput("kd4_last_addr1", 64'(wr_addr[1]), 64'd24);
        checkOutput("kd4_last_data1", 64'(wr_data[1]), 64'h0218);

        // base 60 wraps through 63 -> 0; last address is 31
        applyStimulus(6'd60, 3'd3, 36, 3, -1, 0, -1, 1'b0, 1'b1, 1'b1);
        checkOutput("wrap_last_addr0", 64'(wr_addr[0]), 64'd30);
        checkOutput("wrap_last_addr1", 64'(wr_addr[1]), 64'd31);

        // rd_busy held for 6 cycles mid-job
        applyStimulus(6'd0, 3'd3, 36, 4, 4, 6, -1, 1'b0, 1'b1, 1'b1);

        // negative lane data through the optional clamp
        applyStimulus(6'd0, 3'd7, 4, 5, -1, 0, -1, 1'b1, 1'b1, 1'b1);

        // kernel_dim 0 behaves as 1: full 64-entry map
        applyStimulus(6'd0, 3'd0, 64, 6, -1, 0, -1, 1'b0, 1'b1, 1'b1);
        checkOutput("kd0_last_addr1", 64'(wr_addr[1]), 64'd63);

        // reset while DRAIN holds buffered beats: nothing may be written afterwards
        applyStimulus(6'd0, 3'd7, 4, 7, 0, 100, -1, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_wr_en", 64'(wr_en), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd0);
        checkOutput("abort_wr_data", 64'(wr_data), 64'd0);
        #5 reset = 1'b0;
        rd_busy = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        checkOutput("no_done_after_abort", 64'(done_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
